// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan driver.
package seg7_pkg;

  localparam int         PWM_PHASES = 16;
  localparam logic [7:0] SEG_BLANK  = 8'h00;

  // Entry n holds the g..a pattern for hex digit n (entry 0 is the low slice).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic [3:0] data;
    logic       dp;
    logic       blank;
  } digit_t;

  localparam digit_t DIGIT_RESET = '{data: 4'h0, dp: 1'b0, blank: 1'b1};

  function automatic int digit_idx_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble plus decimal point to active-high segment pattern; blank forces all segments off.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = {dp_i, HEX_SEG[nibble_i]};
    if (blank_i) seg_o = SEG_BLANK;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed seven-segment driver: per-digit registers, frame snapshot,
// PWM brightness with a dead phase per digit, and leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS = 2,
  parameter  int CLK_HZ     = 50_000_000,
  parameter  int REFRESH_HZ = 1000,
  localparam int IDX_W      = digit_idx_width(NUM_DIGITS),
  localparam int PHASE_DIV  = CLK_HZ / (REFRESH_HZ * NUM_DIGITS * PWM_PHASES)
) (
  input  logic                  clkin_50,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_digit,
  input  logic [3:0]            wr_data,
  input  logic                  wr_dp,
  input  logic                  wr_blank,
  input  logic [3:0]            brightness,
  input  logic                  lzb_en,
  output logic [7:0]            seg7_data,
  output logic [NUM_DIGITS-1:0] seg7_char,
  output logic                  frame_tick
);

  localparam int PH_W  = $clog2(PWM_PHASES);
  localparam int PRE_W = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(PHASE_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST      = PH_W'(PWM_PHASES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W:0]   NUM_DIGITS_W = (IDX_W + 1)'(NUM_DIGITS);

  if (NUM_DIGITS < 1) begin : g_bad_num_digits
    $error("seg7_scan_driver: NUM_DIGITS must be at least 1");
  end
  if (PHASE_DIV < 1) begin : g_bad_phase_div
    $error("seg7_scan_driver: CLK_HZ too low for REFRESH_HZ and NUM_DIGITS");
  end

  logic [PRE_W-1:0] presc_q, presc_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             frame_end;

  digit_t [NUM_DIGITS-1:0] work_q, work_d;
  digit_t [NUM_DIGITS-1:0] disp_q, disp_d;
  logic                    wr_hit;

  logic [NUM_DIGITS-1:0] lzb_blank;
  logic                  leading;
  digit_t                cur_digit;
  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] char_d;

  logic [7:0]            seg_q;
  logic [NUM_DIGITS-1:0] char_q;
  logic                  tick_q;

  // Prescaler feeds the 16-phase PWM counter, whose wrap steps the digit index.
  always_comb begin
    presc_d   = presc_q + 1'b1;
    phase_d   = phase_q;
    idx_d     = idx_q;
    frame_end = 1'b0;
    if (presc_q == PRE_LAST) begin
      presc_d = '0;
      phase_d = phase_q + 1'b1;
      if (phase_q == PH_LAST) begin
        if (idx_q == IDX_LAST) begin
          idx_d     = '0;
          frame_end = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

  assign wr_hit = wr_en && ({1'b0, wr_digit} < NUM_DIGITS_W);

  // The snapshot reads work_q, so a write landing in the boundary cycle waits a frame.
  always_comb begin
    work_d = work_q;
    disp_d = disp_q;
    if (wr_hit) work_d[wr_digit] = '{data: wr_data, dp: wr_dp, blank: wr_blank};
    if (frame_end) disp_d = work_q;
  end

  always_comb begin
    lzb_blank = '0;
    leading   = lzb_en;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (disp_q[i].blank || (disp_q[i].data == 4'h0 && !disp_q[i].dp)) lzb_blank[i] = leading;
      else leading = 1'b0;
    end
  end

  assign cur_digit = disp_q[idx_q];

  seg7_hex_decode u_decode (
    .nibble_i (cur_digit.data),
    .dp_i     (cur_digit.dp),
    .blank_i  (cur_digit.blank | lzb_blank[idx_q]),
    .seg_o    (seg_d)
  );

  // Phase 0 stays dark so the previous digit's segments never ghost onto the next.
  always_comb begin
    char_d = '0;
    if (phase_q != '0 && phase_q <= brightness) char_d = NUM_DIGITS'(1) << idx_q;
  end

  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      phase_q <= '0;
      idx_q   <= '0;
      work_q  <= {NUM_DIGITS{DIGIT_RESET}};
      disp_q  <= {NUM_DIGITS{DIGIT_RESET}};
      seg_q   <= SEG_BLANK;
      char_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      disp_q  <= disp_d;
      seg_q   <= seg_d;
      char_q  <= char_d;
      tick_q  <= frame_end;
    end
  end

  assign seg7_data  = seg_q;
  assign seg7_char  = char_q;
  assign frame_tick = tick_q;

endmodule
